// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Accepts a byte over a valid/ready handshake and steps the line through
// start, data, optional parity and stop bits. It drives the PISO load/shift
// strobes and the line-mux select. One baud clock equals one bit time.
//
// state  | meaning
// IDLE   | line high, waiting for a frame
// START  | start bit on line, PISO loads the held payload
// DATA   | payload bits on line LSB first, PISO shifts each cycle
// PARITY | held parity bit on line (only when par_en was set on accept)
// STOP   | line high for STOP_BITS cycles, last one can accept the next frame
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  baud_rate_tx,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  par_en,
    input  logic                  par_odd,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  load,
    output logic                  shift,
    output logic                  parity_bit,
    output logic [1:0]            mux_sel,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    localparam logic [1:0] MUX_HIGH   = 2'b00;
    localparam logic [1:0] MUX_START  = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;

    logic                  ready_q, ready_d;
    logic                  load_q, load_d;
    logic                  shift_q, shift_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            mux_q, mux_d;

    logic                  accept;

    // ready_q is the decode of the current state, so this is the live handshake
    assign accept = tx_valid & ready_q;

    // Next-state, bit counter and frame capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        parity_d = parity_q;

        if (accept) begin
            data_d   = tx_data;
            par_en_d = par_en;
            parity_d = (^tx_data) ^ par_odd;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
                cnt_d   = '0;
            end
            S_STOP: begin
                if (cnt_q == LAST_STOP) begin
                    cnt_d   = '0;
                    state_d = accept ? S_START : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state so the outputs can be registered
    always_comb begin
        ready_d = 1'b0;
        load_d  = 1'b0;
        shift_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        mux_d   = MUX_HIGH;
        case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_START: begin
                mux_d  = MUX_START;
                load_d = 1'b1;
            end
            S_DATA: begin
                mux_d   = MUX_DATA;
                shift_d = 1'b1;
            end
            S_PARITY: begin
                mux_d = MUX_PARITY;
            end
            S_STOP: begin
                if (cnt_d == LAST_STOP) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, held frame and registered outputs; reset aborts any frame in flight
    always_ff @(posedge baud_rate_tx or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            ready_q  <= 1'b1;
            load_q   <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mux_q    <= MUX_HIGH;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            ready_q  <= ready_d;
            load_q   <= load_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mux_q    <= mux_d;
        end
    end

    assign tx_ready   = ready_q;
    assign p_data_out = data_q;
    assign load       = load_q;
    assign shift      = shift_q;
    assign parity_bit = parity_q;
    assign mux_sel    = mux_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: one instance with a single stop bit,
// one with two. A PISO plus line-mux model rebuilds the serial line.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v1 = 1'b0, pe1 = 1'b0, po1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       r1, ld1, sh1, pb1, bz1, dn1;
    logic [7:0] pd1;
    logic [1:0] mx1;

    logic       v2 = 1'b0, pe2 = 1'b0, po2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       r2, ld2, sh2, pb2, bz2, dn2;
    logic [7:0] pd2;
    logic [1:0] mx2;

    logic [7:0] p1, p2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic line;
        logic done;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
        .par_en(pe1), .par_odd(po1), .tx_ready(r1), .p_data_out(pd1),
        .load(ld1), .shift(sh1), .parity_bit(pb1), .mux_sel(mx1),
        .busy(bz1), .tx_done(dn1)
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .baud_rate_tx(clk), .rst(rst), .tx_valid(v2), .tx_data(d2),
        .par_en(pe2), .par_odd(po2), .tx_ready(r2), .p_data_out(pd2),
        .load(ld2), .shift(sh2), .parity_bit(pb2), .mux_sel(mx2),
        .busy(bz2), .tx_done(dn2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic line_of(input logic [1:0] m, input logic s, input logic p);
        case (m)
            2'b00:   return 1'b1;
            2'b01:   return 1'b0;
            2'b10:   return s;
            default: return p;
        endcase
    endfunction

    // PISO models: load captures the held payload, shift moves the next bit to bit 0
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= 8'h00;
            p2 <= 8'h00;
        end else begin
            if (ld1) p1 <= pd1;
            else if (sh1) p1 <= p1 >> 1;
            if (ld2) p2 <= pd2;
            else if (sh2) p2 <= p2 >> 1;
        end
    end

    // Line monitor, single stop bit instance
    always @(negedge clk) begin : mon1
        exp_t e;
        chk("ld_sh_excl1", {31'd0, ld1 & sh1}, 32'd0);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("line1", {31'd0, line_of(mx1, p1[0], pb1)}, {31'd0, e.line});
            chk("done1", {31'd0, dn1}, {31'd0, e.done});
            chk("busy1", {31'd0, bz1}, 32'd1);
        end else begin
            chk("idle_line1", {31'd0, line_of(mx1, p1[0], pb1)}, 32'd1);
            chk("idle_done1", {31'd0, dn1}, 32'd0);
            chk("idle_busy1", {31'd0, bz1}, 32'd0);
            chk("idle_ready1", {31'd0, r1}, 32'd1);
        end
    end

    // Line monitor, two stop bit instance
    always @(negedge clk) begin : mon2
        exp_t e;
        chk("ld_sh_excl2", {31'd0, ld2 & sh2}, 32'd0);
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("line2", {31'd0, line_of(mx2, p2[0], pb2)}, {31'd0, e.line});
            chk("done2", {31'd0, dn2}, {31'd0, e.done});
            chk("busy2", {31'd0, bz2}, 32'd1);
        end else begin
            chk("idle_line2", {31'd0, line_of(mx2, p2[0], pb2)}, 32'd1);
            chk("idle_done2", {31'd0, dn2}, 32'd0);
            chk("idle_busy2", {31'd0, bz2}, 32'd0);
        end
    end

    task automatic push_frame(input int sel, input logic [7:0] d, input logic pe,
                              input logic po, input int nstop);
        exp_t f[$];
        f.push_back('{line: 1'b0, done: 1'b0});
        for (int i = 0; i < 8; i++) f.push_back('{line: d[i], done: 1'b0});
        if (pe) f.push_back('{line: (^d) ^ po, done: 1'b0});
        for (int s = 0; s < nstop; s++) f.push_back('{line: 1'b1, done: (s == nstop - 1)});
        foreach (f[k]) begin
            if (sel == 0) q1.push_back(f[k]);
            else q2.push_back(f[k]);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic pe, input logic po);
        int n = 0;
        if (sel == 0) begin
            d1 = d; pe1 = pe; po1 = po; v1 = 1'b1;
            while (!r1 && n < 200) begin @(negedge clk); n++; end
        end else begin
            d2 = d; pe2 = pe; po2 = po; v2 = 1'b1;
            while (!r2 && n < 200) begin @(negedge clk); n++; end
        end
        if (n >= 200) chk("send_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        push_frame(sel, d, pe, po, (sel == 0) ? 1 : 2);
        if (sel == 0) begin
            v1 = 1'b0; d1 = 8'($urandom); pe1 = 1'($urandom); po1 = 1'($urandom);
        end else begin
            v2 = 1'b0; d2 = 8'($urandom); pe2 = 1'($urandom); po2 = 1'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n < 500}, 32'd1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, r1}, 32'd1);
        chk("rst_pdata", {24'd0, pd1}, 32'd0);
        chk("rst_parity", {31'd0, pb1}, 32'd0);
        chk("rst_mux", {30'd0, mx1}, 32'd0);
        chk("rst_load_shift", {30'd0, ld1, sh1}, 32'd0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;

        // reset in the middle of the data bits
        send(0, 8'hC3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        q1.delete();
        #1;
        chk("rst_mid_mux", {30'd0, mx1}, 32'd0);
        chk("rst_mid_busy", {31'd0, bz1}, 32'd0);
        chk("rst_mid_ready", {31'd0, r1}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_pdata", {24'd0, pd1}, 32'd0);
        #2;

        // plain frame, then even and odd parity
        send(0, 8'h0F, 1'b0, 1'b0);
        drain();
        send(0, 8'h07, 1'b1, 1'b0);
        drain();
        send(0, 8'h07, 1'b1, 1'b1);
        drain();
        chk("parity_held", {31'd0, pb1}, 32'd0);

        // two stop bits
        send(1, 8'hA5, 1'b0, 1'b0);
        drain();

        // back-to-back frames with valid held
        send(0, 8'h55, 1'b0, 1'b0);
        send(0, 8'hAA, 1'b0, 1'b0);
        drain();

        // valid pulse while busy must be ignored
        send(0, 8'h99, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        v1 = 1'b1; d1 = 8'h3C; pe1 = 1'b0;
        @(negedge clk);
        #2 v1 = 1'b0;
        drain();

        // a few random frames on both instances
        for (int i = 0; i < 3; i++) begin
            send(0, 8'($urandom), 1'($urandom), 1'($urandom));
            send(1, 8'($urandom), 1'($urandom), 1'($urandom));
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
